csr_gpio_ctrl: RTL and testbench
================================

// Module: csr_gpio_ctrl
// PURPOSE
//  Parametrised GPIO/CSR slave on the CPU external (xif) split bus. It drives GPIO_W outputs
//  and samples GPIO_W inputs, and adds sticky input-edge capture with a maskable irq_o.
//  It also displays the last CPU IRQ code for a programmable time, then returns to LED data.
//  Sits between sigma_tile xif and board pins.
// PARAMETERS
//  BASE_ADDR      32'h80000000  register window base, 32-byte aligned
//  GPIO_W         32            GPIO in/out width, 8..32; reg bits above GPIO_W read 0
//  IN_SYNC_STAGES 2             input synchroniser depth, >=2
//  IRQ_CODE_W     4             width of CPU irq code
//  STATUS_LSB     16            LSB of 3-bit status field on gpio_bo; STATUS_LSB+3<=GPIO_W
//  SHOW_CYCLES    28'hfffffff   cycles an irq code stays displayed, >=1
// PORTS
//  clk_i         in   1           clock
//  rst_i         in   1           synchronous active-high reset
//  bus_req_i     in   1           bus request
//  bus_we_i      in   1           1=write, 0=read
//  bus_addr_bi   in   32          byte address
//  bus_be_bi     in   4           write byte enables
//  bus_wdata_bi  in   32          write data
//  bus_ack_o     out  1           request accepted (= bus_req_i, combinational)
//  bus_resp_o    out  1           read data valid, 1-cycle pulse
//  bus_rdata_bo  out  32          read data, 0 when bus_resp_o=0
//  gpio_bi       in   GPIO_W      async inputs (switches)
//  gpio_bo       out  GPIO_W      registered outputs (LEDs)
//  irq_code_i    in   IRQ_CODE_W  code of IRQ being acknowledged by CPU
//  irq_ack_i     in   1           CPU irq acknowledge strobe
//  irq_o         out  1           |(EDGE & EDGE_MASK), registered
// BEHAVIOUR
//  Registers (offset, access, reset):
//   0x00 LED RW 0; 0x04 SW RO (synchronised gpio_bi); 0x08 IRQ_CODE RO 0;
//   0x0C IRQ_CNT RO 0, wraps at 2^32; 0x10 EDGE RW1C 0; 0x14 EDGE_MASK RW 0;
//   0x18 CTRL RW 1 (bit0 show_en).
//  Writes honour bus_be_bi per byte, including RW1C on EDGE.
//  Bus: every req is accepted the same cycle. Read at cycle n -> bus_resp_o=1 with data at n+1.
//   Writes produce no resp.
//   Reads to unmapped offsets inside the 32-byte window -> resp with 0.
//   Addresses outside the window -> no resp, no side effects.
//  Inputs: IN_SYNC_STAGES flops, then a prev-sample flop. Rising edge (prev=0, cur=1) sets EDGE[i].
//   Edge detect is disarmed for IN_SYNC_STAGES+1 cycles after reset, so no spurious edges.
//   New edge and W1C on the same bit in the same cycle -> bit stays 1.
//  IRQ capture: irq_ack_i at cycle n -> IRQ_CODE=irq_code_i and IRQ_CNT+=1 at n+1.
//   Capture happens regardless of concurrent bus traffic.
//  Display FSM {S_LED, S_SHOW}; timer is 28-bit.
//   S_LED: gpio_bo = LED with bits [STATUS_LSB+:3] forced to 3'b010.
//   irq_ack_i && show_en -> S_SHOW, timer=0.
//   S_SHOW: gpio_bo = zero-extended IRQ_CODE with [STATUS_LSB+:3] = 3'b100.
//    Timer increments each cycle; at SHOW_CYCLES-1 -> S_LED.
//    irq_ack_i in S_SHOW restarts timer=0 with the new code.
//   Ack at n -> code shown n+1 .. n+SHOW_CYCLES, LED shown at n+SHOW_CYCLES+1.
//   LED writes during S_SHOW update the register only; they appear on exit.
//   Writing show_en=0 in S_SHOW -> S_LED next cycle.
//  Reset (any cycle, incl. mid-show): S_LED, all regs at reset values, bus_resp_o=0,
//   bus_rdata_bo=0, irq_o=0, gpio_bo = 3'b010<<STATUS_LSB.
// STRUCTURE
//  Package csr_gpio_pkg holds:
//   offset localparams (LED..CTRL), status codes ST_LED=3'b010, ST_IRQ=3'b100,
//   display state enum.
//  Sub-module gpio_in_sync: synchroniser, prev flop, arm counter, rising-edge vector out.
//  Top: decode, register file, display FSM/timer, read mux.
// TESTING
//  1 Write LED=32'h0000_00A5, be=4'hF; read 0x00 -> resp at n+1, rdata=32'hA5;
//    gpio_bo=32'h0002_00A5.
//  2 Write LED=32'hFFFF_FFFF with be=4'h1 -> LED reads 32'h0000_00FF.
//    Read 0x1C -> resp, 0. Read BASE+0x20 -> no resp.
//  3 SHOW_CYCLES=8: irq_ack_i with code 4'h5 at n -> gpio_bo=32'h0004_0005 for n+1..n+8,
//    LED value back at n+9. IRQ_CNT=1.
//  4 SHOW_CYCLES=8: second ack (code 3) at n+4 -> code 3 shown until n+12.
//    Ack concurrent with a bus read is still captured: IRQ_CNT=2.
//  5 EDGE_MASK=1; gpio_bi[0] 0->1 -> EDGE[0]=1 after IN_SYNC_STAGES+2 cycles, irq_o=1 next.
//    W1C bit 0 -> irq_o=0. W1C coincident with new edge -> EDGE[0] stays 1.
//  6 gpio_bi=all-1 across reset release -> EDGE stays 0.
//    Reset asserted in S_SHOW -> gpio_bo=32'h0002_0000 next cycle.

Source files
------------

// File: rtl/csr_gpio_pkg.sv
// Shared definitions for the GPIO/CSR slave: register offsets, status codes,
// display state encoding and the byte-enable expansion helper.
package csr_gpio_pkg;

    localparam logic [4:0] OFF_LED       = 5'h00;
    localparam logic [4:0] OFF_SW        = 5'h04;
    localparam logic [4:0] OFF_IRQ_CODE  = 5'h08;
    localparam logic [4:0] OFF_IRQ_CNT   = 5'h0C;
    localparam logic [4:0] OFF_EDGE      = 5'h10;
    localparam logic [4:0] OFF_EDGE_MASK = 5'h14;
    localparam logic [4:0] OFF_CTRL      = 5'h18;

    localparam logic [2:0] ST_LED = 3'b010;
    localparam logic [2:0] ST_IRQ = 3'b100;

    typedef enum logic {S_LED, S_SHOW} disp_state_t;

    // Expand 4 byte enables into a 32-bit bit mask.
    function automatic logic [31:0] be_mask(input logic [3:0] be);
        logic [31:0] m;
        for (int b = 0; b < 4; b++) m[b*8 +: 8] = {8{be[b]}};
        return m;
    endfunction

endpackage

// File: rtl/csr_gpio_ctrl_in_sync.sv
// Input conditioning: multi-flop synchroniser, previous-sample flop and a
// registered rising-edge vector. Edges are suppressed until the chain has
// been refilled after reset so a pin held high never looks like a new edge.
module gpio_in_sync #(
    parameter int W      = 32,
    parameter int STAGES = 2
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic [W-1:0] pins_i,
    output logic [W-1:0] sync_o,
    output logic [W-1:0] rise_o
);

    localparam int ARM_MAX = STAGES + 1;
    localparam int ARM_W   = $clog2(STAGES + 2);

    logic [STAGES-1:0][W-1:0] sync_q;
    logic [W-1:0]             prev_q;
    logic [W-1:0]             rise_q;
    logic [ARM_W-1:0]         arm_cnt;
    logic                     armed;

    assign armed  = (arm_cnt == ARM_W'(ARM_MAX));
    assign sync_o = sync_q[STAGES-1];
    assign rise_o = rise_q;

    // Shift chain, prev sample, gated edge register and arm counter.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sync_q  <= '0;
            prev_q  <= '0;
            rise_q  <= '0;
            arm_cnt <= '0;
        end else begin
            sync_q[0] <= pins_i;
            for (int i = 1; i < STAGES; i++) sync_q[i] <= sync_q[i-1];
            prev_q <= sync_q[STAGES-1];
            rise_q <= armed ? (sync_q[STAGES-1] & ~prev_q) : '0;
            if (!armed) arm_cnt <= arm_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/csr_gpio_ctrl.sv
// GPIO/CSR slave on the xif split bus: LED outputs with a status field,
// synchronised switch inputs with sticky edge capture and maskable irq,
// and a timed display of the last acknowledged CPU irq code.
module csr_gpio_ctrl
    import csr_gpio_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR      = 32'h8000_0000,
    parameter int          GPIO_W         = 32,
    parameter int          IN_SYNC_STAGES = 2,
    parameter int          IRQ_CODE_W     = 4,
    parameter int          STATUS_LSB     = 16,
    parameter logic [27:0] SHOW_CYCLES    = 28'hfffffff
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  bus_req_i,
    input  logic                  bus_we_i,
    input  logic [31:0]           bus_addr_bi,
    input  logic [3:0]            bus_be_bi,
    input  logic [31:0]           bus_wdata_bi,
    output logic                  bus_ack_o,
    output logic                  bus_resp_o,
    output logic [31:0]           bus_rdata_bo,
    input  logic [GPIO_W-1:0]     gpio_bi,
    output logic [GPIO_W-1:0]     gpio_bo,
    input  logic [IRQ_CODE_W-1:0] irq_code_i,
    input  logic                  irq_ack_i,
    output logic                  irq_o
);

    localparam logic [GPIO_W-1:0] GPIO_RST  = GPIO_W'(ST_LED) << STATUS_LSB;
    localparam logic [27:0]       SHOW_LAST = SHOW_CYCLES - 28'd1;

    logic              in_win, wr, rd, ctrl_clr;
    logic [4:0]        off;
    logic [31:0]       wmask32, wbits32;
    logic [GPIO_W-1:0] wmask, wbits;
    logic [GPIO_W-1:0] sw_sync, rise;

    logic [GPIO_W-1:0]     led_q, edge_q, emask_q, gpio_q;
    logic [GPIO_W-1:0]     led_d, edge_d, emask_d, gpio_d;
    logic [IRQ_CODE_W-1:0] code_q, code_d;
    logic [31:0]           cnt_q, cnt_d;
    logic                  show_en_q, show_en_d;
    disp_state_t           state_q, state_d;
    logic [27:0]           timer_q, timer_d;
    logic                  irq_q, resp_q;
    logic [31:0]           rdata_q, rd_val;

    gpio_in_sync #(.W(GPIO_W), .STAGES(IN_SYNC_STAGES)) u_in_sync (
        .clk_i  (clk_i),
        .rst_i  (rst_i),
        .pins_i (gpio_bi),
        .sync_o (sw_sync),
        .rise_o (rise)
    );

    assign in_win   = (bus_addr_bi[31:5] == BASE_ADDR[31:5]);
    assign off      = bus_addr_bi[4:0];
    assign wr       = bus_req_i & bus_we_i & in_win;
    assign rd       = bus_req_i & ~bus_we_i & in_win;
    assign wmask32  = be_mask(bus_be_bi);
    assign wbits32  = bus_wdata_bi & wmask32;
    assign wmask    = wmask32[GPIO_W-1:0];
    assign wbits    = wbits32[GPIO_W-1:0];
    assign ctrl_clr = wr && (off == OFF_CTRL) && bus_be_bi[0] && !bus_wdata_bi[0];

    assign bus_ack_o    = bus_req_i;
    assign bus_resp_o   = resp_q;
    assign bus_rdata_bo = rdata_q;
    assign gpio_bo      = gpio_q;
    assign irq_o        = irq_q;

    // Register file next values: byte-masked writes, W1C edges, irq capture.
    always_comb begin
        led_d     = led_q;
        emask_d   = emask_q;
        show_en_d = show_en_q;
        edge_d    = edge_q | rise;
        code_d    = code_q;
        cnt_d     = cnt_q;
        if (wr) begin
            case (off)
                OFF_LED:       led_d     = (led_q & ~wmask) | wbits;
                OFF_EDGE:      edge_d    = (edge_q & ~wbits) | rise;
                OFF_EDGE_MASK: emask_d   = (emask_q & ~wmask) | wbits;
                OFF_CTRL:      if (bus_be_bi[0]) show_en_d = bus_wdata_bi[0];
                default: ;
            endcase
        end
        if (irq_ack_i) begin
            code_d = irq_code_i;
            cnt_d  = cnt_q + 32'd1;
        end
    end

    // Display FSM: hold an irq code on the pins for SHOW_CYCLES, then LEDs.
    always_comb begin
        state_d = state_q;
        timer_d = timer_q;
        case (state_q)
            S_LED: begin
                if (irq_ack_i && show_en_q) begin
                    state_d = S_SHOW;
                    timer_d = '0;
                end
            end
            S_SHOW: begin
                if (ctrl_clr)                  state_d = S_LED;
                else if (irq_ack_i)            timer_d = '0;
                else if (timer_q == SHOW_LAST) state_d = S_LED;
                else                           timer_d = timer_q + 28'd1;
            end
            default: state_d = S_LED;
        endcase
    end

    // Pin image built from next-cycle values so gpio_bo is a plain flop.
    always_comb begin
        gpio_d = led_d;
        gpio_d[STATUS_LSB +: 3] = ST_LED;
        if (state_d == S_SHOW) begin
            gpio_d = '0;
            gpio_d[IRQ_CODE_W-1:0]  = code_d;
            gpio_d[STATUS_LSB +: 3] = ST_IRQ;
        end
    end

    // Read mux; narrow registers are zero-extended.
    always_comb begin
        rd_val = '0;
        case (off)
            OFF_LED:       rd_val[GPIO_W-1:0]     = led_q;
            OFF_SW:        rd_val[GPIO_W-1:0]     = sw_sync;
            OFF_IRQ_CODE:  rd_val[IRQ_CODE_W-1:0] = code_q;
            OFF_IRQ_CNT:   rd_val                 = cnt_q;
            OFF_EDGE:      rd_val[GPIO_W-1:0]     = edge_q;
            OFF_EDGE_MASK: rd_val[GPIO_W-1:0]     = emask_q;
            OFF_CTRL:      rd_val[0]              = show_en_q;
            default: ;
        endcase
    end

    // State registers, bus response and registered outputs.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            led_q     <= '0;
            edge_q    <= '0;
            emask_q   <= '0;
            code_q    <= '0;
            cnt_q     <= '0;
            show_en_q <= 1'b1;
            state_q   <= S_LED;
            timer_q   <= '0;
            gpio_q    <= GPIO_RST;
            irq_q     <= 1'b0;
            resp_q    <= 1'b0;
            rdata_q   <= '0;
        end else begin
            led_q     <= led_d;
            edge_q    <= edge_d;
            emask_q   <= emask_d;
            code_q    <= code_d;
            cnt_q     <= cnt_d;
            show_en_q <= show_en_d;
            state_q   <= state_d;
            timer_q   <= timer_d;
            gpio_q    <= gpio_d;
            irq_q     <= |(edge_q & emask_q);
            resp_q    <= rd;
            rdata_q   <= rd ? rd_val : '0;
        end
    end

endmodule

// File: tb/tb_csr_gpio_ctrl.sv
// Bench for csr_gpio_ctrl: a register-level model (countdown for the display,
// sample history for the input path) checked every cycle, plus literal checks.
module tb_csr_gpio_ctrl;
    localparam logic [31:0] BASE = 32'h8000_0000;
    localparam int S  = 2;
    localparam int SC = 8;

    logic        clk = 1'b0, rst = 1'b1;
    logic        req = 1'b0, we = 1'b0;
    logic [31:0] addr = '0, wdata = '0;
    logic [3:0]  be = '0;
    logic [31:0] gpio_in = '0;
    logic [3:0]  code = '0;
    logic        ack = 1'b0;
    logic        bus_ack, bus_resp, irq;
    logic [31:0] bus_rdata, gpio_out;

    int checks = 0, failures = 0;

    csr_gpio_ctrl #(
        .BASE_ADDR(BASE), .GPIO_W(32), .IN_SYNC_STAGES(S), .IRQ_CODE_W(4),
        .STATUS_LSB(16), .SHOW_CYCLES(28'(SC))
    ) dut (
        .clk_i(clk), .rst_i(rst), .bus_req_i(req), .bus_we_i(we),
        .bus_addr_bi(addr), .bus_be_bi(be), .bus_wdata_bi(wdata),
        .bus_ack_o(bus_ack), .bus_resp_o(bus_resp), .bus_rdata_bo(bus_rdata),
        .gpio_bi(gpio_in), .gpio_bo(gpio_out), .irq_code_i(code),
        .irq_ack_i(ack), .irq_o(irq)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic [31:0] m_led, m_edge, m_mask, m_cnt, m_rdata, m_gpio;
    logic [3:0]  m_code;
    logic        m_show_en, m_resp, m_irq, started = 1'b0;
    int          show_left;
    logic [31:0] hist[$];

    function automatic logic [31:0] m_read(input logic [4:0] o, input logic [31:0] sw);
        case (o)
            5'h00: return m_led;
            5'h04: return sw;
            5'h08: return {28'd0, m_code};
            5'h0C: return m_cnt;
            5'h10: return m_edge;
            5'h14: return m_mask;
            5'h18: return {31'd0, m_show_en};
            default: return 32'd0;
        endcase
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            m_led = 0; m_edge = 0; m_mask = 0; m_cnt = 0; m_code = 0;
            m_show_en = 1; show_left = 0; m_resp = 0; m_rdata = 0; m_irq = 0;
            hist.delete();
            started = 1'b1;
        end else begin
            logic [31:0] sw, rise;
            logic        inwin, old_en;
            sw    = (hist.size() >= S) ? hist[hist.size()-S] : 32'd0;
            rise  = (hist.size() >= S+2) ?
                    (hist[hist.size()-1-S] & ~hist[hist.size()-2-S]) : 32'd0;
            inwin = (addr >= BASE) && (addr < BASE + 32);
            m_resp  = req && !we && inwin;
            m_rdata = m_resp ? m_read(addr[4:0], sw) : 32'd0;
            m_irq   = |(m_edge & m_mask);
            old_en  = m_show_en;
            if (show_left > 0 && req && we && inwin && addr[4:0] == 5'h18 && be[0] && !wdata[0])
                show_left = 0;
            else if (ack && (show_left > 0 || old_en))
                show_left = SC;
            else if (show_left > 0)
                show_left--;
            if (req && we && inwin) begin
                for (int b = 0; b < 4; b++) if (be[b]) begin
                    case (addr[4:0])
                        5'h00: m_led[b*8 +: 8]  = wdata[b*8 +: 8];
                        5'h10: m_edge[b*8 +: 8] = m_edge[b*8 +: 8] & ~wdata[b*8 +: 8];
                        5'h14: m_mask[b*8 +: 8] = wdata[b*8 +: 8];
                        5'h18: if (b == 0) m_show_en = wdata[0];
                        default: ;
                    endcase
                end
            end
            m_edge = m_edge | rise;
            if (ack) begin m_code = code; m_cnt = m_cnt + 1; end
            hist.push_back(gpio_in);
        end
        m_gpio = (show_left > 0) ? (32'h0004_0000 | {28'd0, m_code})
                                 : ((m_led & ~32'h0007_0000) | 32'h0002_0000);
    end

    // Every-cycle comparison, half a period after the active edge.
    always @(negedge clk) begin
        if (started) begin
            chk("ack", {31'd0, bus_ack}, {31'd0, req});
            chk("resp", {31'd0, bus_resp}, {31'd0, m_resp});
            chk("rdata", bus_rdata, m_rdata);
            chk("gpio_bo", gpio_out, m_gpio);
            chk("irq_o", {31'd0, irq}, {31'd0, m_irq});
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge clk); #2;
    endtask

    task automatic wr(input logic [31:0] a, input logic [3:0] b, input logic [31:0] d);
        req = 1; we = 1; addr = a; be = b; wdata = d;
        tick();
        req = 0; we = 0; be = 0;
    endtask

    task automatic rd(input logic [31:0] a, output logic r, output logic [31:0] d);
        req = 1; we = 0; addr = a;
        tick();
        r = bus_resp; d = bus_rdata;
        req = 0;
    endtask

    task automatic rd_chk(input string name, input logic [31:0] a, input logic r_exp,
                          input logic [31:0] d_exp);
        logic r; logic [31:0] d;
        rd(a, r, d);
        chk({name, "_resp"}, {31'd0, r}, {31'd0, r_exp});
        chk(name, d, d_exp);
    endtask

    task automatic irq_ack(input logic [3:0] c);
        code = c; ack = 1;
        tick();
        ack = 0;
    endtask

    initial begin
        logic r; logic [31:0] d;
        repeat (3) tick();
        rst = 0;
        chk("rst_gpio", gpio_out, 32'h0002_0000);
        chk("rst_irq", {31'd0, irq}, 32'd0);
        rd_chk("rst_ctrl", BASE + 32'h18, 1, 32'd1);
        rd_chk("rst_cnt", BASE + 32'h0C, 1, 32'd0);

        // 1: LED write and readback
        wr(BASE, 4'hF, 32'h0000_00A5);
        rd_chk("led_a5", BASE, 1, 32'h0000_00A5);
        chk("gpio_a5", gpio_out, 32'h0002_00A5);

        // 2: byte enables, unmapped offset, out-of-window
        wr(BASE, 4'h1, 32'hFFFF_FFFF);
        rd_chk("led_be", BASE, 1, 32'h0000_00FF);
        rd_chk("unmapped", BASE + 32'h1C, 1, 32'd0);
        rd_chk("outside", BASE + 32'h20, 0, 32'd0);
        wr(BASE + 32'h20, 4'hF, 32'h0);
        rd_chk("led_kept", BASE, 1, 32'h0000_00FF);

        // 3: irq code display for SHOW_CYCLES
        irq_ack(4'h5);
        for (int k = 0; k < SC; k++) begin
            chk("show5", gpio_out, 32'h0004_0005);
            tick();
        end
        chk("led_back", gpio_out, 32'h0002_00FF);
        rd_chk("cnt1", BASE + 32'h0C, 1, 32'd1);
        rd_chk("code5", BASE + 32'h08, 1, 32'd5);

        // 4: restart mid-show, ack concurrent with a bus read
        rst = 1; tick(); rst = 0;
        irq_ack(4'h5);
        repeat (3) tick();
        code = 4'h3; ack = 1;
        rd(BASE + 32'h0C, r, d);
        ack = 0;
        chk("cnt_old", d, 32'd1);
        for (int k = 0; k < SC; k++) begin
            chk("show3", gpio_out, 32'h0004_0003);
            tick();
        end
        chk("led_back2", gpio_out, 32'h0002_0000);
        rd_chk("cnt2", BASE + 32'h0C, 1, 32'd2);

        // show_en control
        wr(BASE + 32'h18, 4'h1, 32'd0);
        irq_ack(4'h7);
        chk("noshow", gpio_out, 32'h0002_0000);
        wr(BASE + 32'h18, 4'h1, 32'd1);
        irq_ack(4'h7);
        chk("show7", gpio_out, 32'h0004_0007);
        wr(BASE + 32'h18, 4'h1, 32'd0);
        chk("show_cut", gpio_out, 32'h0002_0000);
        wr(BASE + 32'h18, 4'h1, 32'd1);

        // 5: edge capture, irq, W1C, W1C vs. new edge
        wr(BASE + 32'h14, 4'hF, 32'd1);
        repeat (4) tick();
        gpio_in = 32'd1;
        repeat (S + 2) tick();
        chk("irq_pre", {31'd0, irq}, 32'd0);
        tick();
        chk("irq_set", {31'd0, irq}, 32'd1);
        rd_chk("edge_set", BASE + 32'h10, 1, 32'd1);
        wr(BASE + 32'h10, 4'h1, 32'd1);
        tick();
        chk("irq_clr", {31'd0, irq}, 32'd0);
        gpio_in = 32'd0;
        repeat (5) tick();
        gpio_in = 32'd1;
        repeat (S + 1) tick();
        wr(BASE + 32'h10, 4'h1, 32'd1);
        rd_chk("edge_race", BASE + 32'h10, 1, 32'd1);
        wr(BASE + 32'h10, 4'hF, 32'hFFFF_FFFF);

        // SW readback of a stable pattern
        gpio_in = 32'h1234_5678;
        repeat (4) tick();
        rd_chk("sw", BASE + 32'h04, 1, 32'h1234_5678);

        // 6: pins high across reset, reset mid-show
        gpio_in = 32'hFFFF_FFFF;
        rst = 1; repeat (3) tick(); rst = 0;
        repeat (10) tick();
        rd_chk("edge_none", BASE + 32'h10, 1, 32'd0);
        irq_ack(4'h9);
        tick();
        chk("show9", gpio_out, 32'h0004_0009);
        rst = 1; tick();
        chk("rst_show", gpio_out, 32'h0002_0000);
        rst = 0;
        repeat (3) tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
